// File: rtl/rom_saver_pkg.sv
// Shared types and constants for the save-data uploader: FSM states,
// host file-type codes and the ioctl index each file type maps to.
package rom_saver_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_CAPTURE,
        ST_PRESENT
    } state_t;

    localparam logic [2:0]  FT_ROM    = 3'b111;
    localparam logic [2:0]  FT_O      = 3'b010;
    localparam logic [2:0]  FT_P      = 3'b001;

    localparam logic [15:0] IDX_ROM   = 16'h0000;
    localparam logic [15:0] IDX_O     = 16'h001F;
    localparam logic [15:0] IDX_OTHER = 16'h005F;

    localparam int ADDR_W = 22;

    // .p files and unknown types share the same index.
    function automatic logic [15:0] file_index(input logic [2:0] file_type);
        logic [15:0] idx;
        idx = IDX_OTHER;
        case (file_type)
            FT_ROM:  idx = IDX_ROM;
            FT_O:    idx = IDX_O;
            FT_P:    idx = IDX_OTHER;
            default: idx = IDX_OTHER;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/rom_saver_if.sv
// Host-side save-data handshake: upload session level, word request/ack,
// packed word, byte size and file type.
interface rom_saver_if;
    logic        host_savedata_upload;
    logic        host_savedata_req;
    logic        host_savedata_ack;
    logic [31:0] host_savedata;
    logic [15:0] host_savedata_size;
    logic [2:0]  host_file_type;

    modport master (
        output host_savedata_upload,
        output host_savedata_req,
        output host_savedata_size,
        output host_file_type,
        input  host_savedata_ack,
        input  host_savedata
    );

    modport slave (
        input  host_savedata_upload,
        input  host_savedata_req,
        input  host_savedata_size,
        input  host_file_type,
        output host_savedata_ack,
        output host_savedata
    );
endinterface

// File: rtl/rom_saver_word_packer.sv
// Four byte lanes assembled big-endian (first byte in [31:24]); lanes not
// written since the last clear read as zero, which pads a short final word.
module word_packer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        wr_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        last_lane
);

    logic [7:0] lanes [4];
    logic [1:0] lane_sel;

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            for (int i = 0; i < 4; i++) begin
                lanes[i] <= 8'h00;
            end
            lane_sel <= 2'd0;
        end else if (wr_en) begin
            lanes[lane_sel] <= byte_in;
            lane_sel        <= lane_sel + 2'd1;
        end
    end

    assign word      = {lanes[0], lanes[1], lanes[2], lanes[3]};
    assign last_lane = (lane_sel == 2'd3);

endmodule

// File: rtl/rom_saver.sv
// Streams host_savedata_size bytes from the ioctl byte port into 32-bit words
// for the host. Define ROM_SAVER_CHECKSUM_EN to add a 16-bit byte-sum output.
//
// state   | meaning
// IDLE    | waiting for a host word request
// READ    | ioctl_rd high for one cycle
// WAIT    | covers the remaining RD_LATENCY-1 cycles
// CAPTURE | byte into next lane, bump address and byte count
// PRESENT | ack high with the packed word until req drops
module rom_saver
    import rom_saver_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    rom_saver_if.slave        host,
    output logic              ioctl_upload,
    output logic [15:0]       ioctl_index,
    output logic              ioctl_rd,
    output logic [26:0]       ioctl_addr,
    input  logic [7:0]        ioctl_din,
    output logic              upload_done
`ifdef ROM_SAVER_CHECKSUM_EN
    ,
    output logic [15:0]       checksum
`endif
);

    state_t            state;
    logic [1:0]        wait_cnt;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       byte_cnt;
    logic [15:0]       byte_cnt_nxt;
    logic              upload_q;
    logic              ack;
    logic [31:0]       word_q;
    logic              rd;
    logic              done;
    logic              restart;
    logic              upload;
    logic              pk_wr;
    logic              pk_clear;
    logic              pk_last;
    logic [31:0]       pk_word;
`ifdef ROM_SAVER_CHECKSUM_EN
    logic [15:0]       sum;
`endif

    assign upload       = host.host_savedata_upload;
    assign restart      = upload && !upload_q;
    assign byte_cnt_nxt = byte_cnt + 16'd1;

    assign pk_wr    = (state == ST_CAPTURE) && upload && !restart;
    assign pk_clear = restart
                   || ((state == ST_PRESENT) && ack && !host.host_savedata_req && upload);

    word_packer u_packer (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (pk_clear),
        .wr_en     (pk_wr),
        .byte_in   (ioctl_din),
        .word      (pk_word),
        .last_lane (pk_last)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            wait_cnt <= 2'd0;
            addr     <= '0;
            byte_cnt <= 16'd0;
            upload_q <= 1'b0;
            ack      <= 1'b0;
            word_q   <= 32'd0;
            rd       <= 1'b0;
            done     <= 1'b1;
`ifdef ROM_SAVER_CHECKSUM_EN
            sum      <= 16'd0;
`endif
        end else begin
            upload_q <= upload;
            rd       <= 1'b0;
            if (restart) begin
                state    <= ST_IDLE;
                ack      <= 1'b0;
                addr     <= '0;
                byte_cnt <= 16'd0;
                done     <= (host.host_savedata_size == 16'd0);
`ifdef ROM_SAVER_CHECKSUM_EN
                sum      <= 16'd0;
`endif
            end else if (!upload) begin
                state <= ST_IDLE;
                ack   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (host.host_savedata_req) begin
                            if (done) begin
                                state <= ST_PRESENT;
                            end else begin
                                state <= ST_READ;
                                rd    <= 1'b1;
                            end
                        end
                    end
                    ST_READ: begin
                        if (RD_LATENCY > 1) begin
                            state    <= ST_WAIT;
                            wait_cnt <= 2'(RD_LATENCY - 2);
                        end else begin
                            state <= ST_CAPTURE;
                        end
                    end
                    ST_WAIT: begin
                        if (wait_cnt == 2'd0) begin
                            state <= ST_CAPTURE;
                        end else begin
                            wait_cnt <= wait_cnt - 2'd1;
                        end
                    end
                    ST_CAPTURE: begin
                        addr     <= addr + 1'b1;
                        byte_cnt <= byte_cnt_nxt;
`ifdef ROM_SAVER_CHECKSUM_EN
                        sum      <= sum + 16'(ioctl_din);
`endif
                        if (byte_cnt_nxt == host.host_savedata_size) begin
                            done <= 1'b1;
                        end
                        if (pk_last || (byte_cnt_nxt == host.host_savedata_size)) begin
                            state <= ST_PRESENT;
                        end else begin
                            state <= ST_READ;
                            rd    <= 1'b1;
                        end
                    end
                    ST_PRESENT: begin
                        // First cycle latches the word; ack then holds it steady.
                        if (!ack) begin
                            ack    <= 1'b1;
                            word_q <= pk_word;
                        end else if (!host.host_savedata_req) begin
                            ack   <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        ioctl_index = file_index(host.host_file_type);
    end

    assign ioctl_upload           = upload;
    assign ioctl_rd               = rd;
    assign ioctl_addr             = {5'b0, addr};
    assign upload_done            = done;
    assign host.host_savedata_ack = ack;
    assign host.host_savedata     = word_q;
`ifdef ROM_SAVER_CHECKSUM_EN
    assign checksum               = sum;
`endif

endmodule

// File: tb/tb_rom_saver.sv
// Scoreboard bench for rom_saver: one instance at RD_LATENCY=1, one at 3.
// Checksum checks are compiled in when ROM_SAVER_CHECKSUM_EN is defined.
`timescale 1ns/1ps
module tb_rom_saver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n;
    logic [1:0]        upload, req, ack, rd, done, up_out;
    logic [1:0][15:0]  size;
    logic [1:0][2:0]   ftype;
    logic [1:0][31:0]  sdata;
    logic [1:0][15:0]  idx;
    logic [1:0][26:0]  addr;
    logic [1:0][7:0]   din;
`ifdef ROM_SAVER_CHECKSUM_EN
    logic [1:0][15:0]  csum;
`endif

    rom_saver_if if1 ();
    rom_saver_if if3 ();

    assign if1.host_savedata_upload = upload[0];
    assign if1.host_savedata_req    = req[0];
    assign if1.host_savedata_size   = size[0];
    assign if1.host_file_type       = ftype[0];
    assign ack[0]                   = if1.host_savedata_ack;
    assign sdata[0]                 = if1.host_savedata;
    assign if3.host_savedata_upload = upload[1];
    assign if3.host_savedata_req    = req[1];
    assign if3.host_savedata_size   = size[1];
    assign if3.host_file_type       = ftype[1];
    assign ack[1]                   = if3.host_savedata_ack;
    assign sdata[1]                 = if3.host_savedata;

    rom_saver #(.RD_LATENCY(1)) dut1 (
        .clk          (clk),
        .reset_n      (reset_n),
        .host         (if1.slave),
        .ioctl_upload (up_out[0]),
        .ioctl_index  (idx[0]),
        .ioctl_rd     (rd[0]),
        .ioctl_addr   (addr[0]),
        .ioctl_din    (din[0]),
        .upload_done  (done[0])
`ifdef ROM_SAVER_CHECKSUM_EN
        ,
        .checksum     (csum[0])
`endif
    );

    rom_saver #(.RD_LATENCY(3)) dut3 (
        .clk          (clk),
        .reset_n      (reset_n),
        .host         (if3.slave),
        .ioctl_upload (up_out[1]),
        .ioctl_index  (idx[1]),
        .ioctl_rd     (rd[1]),
        .ioctl_addr   (addr[1]),
        .ioctl_din    (din[1]),
        .upload_done  (done[1])
`ifdef ROM_SAVER_CHECKSUM_EN
        ,
        .checksum     (csum[1])
`endif
    );

    int          n_tests;
    int          n_fail;
    int          lat [2] = '{1, 3};
    logic [7:0]  mem [2][64];
    int          m_idx [2];
    int          m_size [2];
    int          rd_base [2];
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];

    int              exp_addr [2];
    int              rd_cnt [2];
    logic [1:0]      ack_q, rd_q, up_q;
    logic [31:0]     last_w [2];
    logic [1:0][3:0][8:0] pipe;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Memory model and monitor: returns bytes RD_LATENCY cycles after a strobe,
    // checks strobe addresses and pops the scoreboard on each ack rise.
    initial begin
        ack_q = '0; rd_q = '0; up_q = '0; pipe = '0; din = '0;
        exp_addr = '{0, 0}; rd_cnt = '{0, 0};
        last_w = '{32'd0, 32'd0};
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                for (int i = 3; i > 0; i--) pipe[g][i] = pipe[g][i-1];
                pipe[g][0] = {rd[g], rd[g] ? mem[g][addr[g][5:0]] : 8'($urandom)};
                din[g] = pipe[g][lat[g]][7:0];
                if (rd[g]) begin
                    rd_cnt[g]++;
                    check("rd_addr", 32'(addr[g]), 32'(exp_addr[g]));
                    check("rd_in_range", 32'(addr[g] < 27'(size[g])), 32'd1);
                    check("rd_one_cycle", 32'(rd_q[g]), 32'd0);
                    exp_addr[g]++;
                end
                if (!reset_n || (upload[g] && !up_q[g])) exp_addr[g] = 0;
                if (ack[g] && !ack_q[g]) begin
                    if ((g == 0 ? q0.size() : q1.size()) == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_ack: inst %0d word %h with empty scoreboard", g, sdata[g]);
                    end else begin
                        check("word", sdata[g], g == 0 ? q0.pop_front() : q1.pop_front());
                    end
                    last_w[g] = sdata[g];
                end else if (ack[g]) begin
                    check("ack_data_stable", sdata[g], last_w[g]);
                end
                ack_q[g] = ack[g];
                rd_q[g]  = rd[g];
                up_q[g]  = upload[g];
            end
        end
    end

    task automatic restart(input int g, input int sz, input bit ramp);
        upload[g] = 1'b0;
        tick(2);
        size[g] = 16'(sz);
        for (int i = 0; i < 64; i++) mem[g][i] = ramp ? 8'(i + 1) : 8'($urandom);
        m_idx[g]  = 0;
        m_size[g] = sz;
        upload[g] = 1'b1;
        tick(2);
        check("done_after_restart", 32'(done[g]), 32'(sz == 0));
        rd_base[g] = rd_cnt[g];
    endtask

    // Expected word: the next four bytes of the file, zero past the end.
    task automatic host_word(input int g, input int extra);
        int nb;
        int cnt;
        logic [31:0] w;
        nb = 0;
        w  = 32'd0;
        for (int k = 0; k < 4; k++) begin
            if (m_idx[g] + k < m_size[g]) begin
                w[31-8*k -: 8] = mem[g][m_idx[g]+k];
                nb++;
            end
        end
        m_idx[g] += nb;
        if (g == 0) q0.push_back(w); else q1.push_back(w);
        req[g] = 1'b1;
        cnt = 0;
        while (!ack[g] && cnt < 400) begin
            tick(1);
            cnt++;
        end
        check("ack_latency", 32'(cnt - 1), 32'(nb * (lat[g] + 1) + 1 + extra));
        req[g] = 1'b0;
        cnt = 0;
        while (ack[g] && cnt < 20) begin
            tick(1);
            cnt++;
        end
        check("ack_fall", 32'(ack[g]), 32'd0);
    endtask

    task automatic session(input int g);
        int nw;
        nw = (m_size[g] + 3) / 4 + 1;
        for (int i = 0; i < nw; i++) host_word(g, 0);
        check("rd_count", 32'(rd_cnt[g] - rd_base[g]), 32'(m_size[g]));
        check("done_end", 32'(done[g]), 32'd1);
    endtask

    task automatic wait_addr(input int g, input int a);
        int cnt;
        cnt = 0;
        while (addr[g] != 27'(a) && cnt < 200) begin
            tick(1);
            cnt++;
        end
        check("wait_addr", 32'(addr[g]), 32'(a));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        upload  = '0;
        req     = '0;
        size    = '0;
        ftype   = '0;
        m_idx   = '{0, 0};
        m_size  = '{0, 0};
        rd_base = '{0, 0};
        tick(3);
        for (int g = 0; g < 2; g++) begin
            check("rst_ack",   32'(ack[g]),  32'd0);
            check("rst_rd",    32'(rd[g]),   32'd0);
            check("rst_addr",  32'(addr[g]), 32'd0);
            check("rst_data",  sdata[g],     32'd0);
            check("rst_done",  32'(done[g]), 32'd1);
        end
        reset_n = 1'b1;
        tick(1);

        for (int g = 0; g < 2; g++) begin
            for (int ft = 0; ft < 8; ft++) begin
                ftype[g]  = 3'(ft);
                upload[g] = ft[0];
                tick(1);
                check("ioctl_index", 32'(idx[g]),
                      ft == 7 ? 32'h0000 : (ft == 2 ? 32'h001F : 32'h005F));
                check("ioctl_upload", 32'(up_out[g]), 32'(ft[0]));
            end
        end

        // Full words, partial final word, empty file.
        restart(0, 8, 1'b1);
        session(0);
        restart(0, 5, 1'b1);
        session(0);
        restart(0, 0, 1'b0);
        session(0);

        // Reset after the second byte of a word.
        restart(0, 16, 1'b0);
        req[0] = 1'b1;
        wait_addr(0, 2);
        reset_n = 1'b0;
        tick(1);
        check("midrst_ack",  32'(ack[0]),  32'd0);
        check("midrst_rd",   32'(rd[0]),   32'd0);
        check("midrst_addr", 32'(addr[0]), 32'd0);
        check("midrst_done", 32'(done[0]), 32'd1);
        reset_n = 1'b1;
        req[0]  = 1'b0;
        tick(1);
        restart(0, 16, 1'b0);
        session(0);

        // Restart mid-word at RD_LATENCY=3 with req held through the restart.
        restart(1, 8, 1'b1);
        req[1] = 1'b1;
        wait_addr(1, 2);
        upload[1] = 1'b0;
        tick(1);
        check("upload_low_ack", 32'(ack[1]), 32'd0);
        rd_base[1] = rd_cnt[1];
        m_idx[1]   = 0;
        upload[1]  = 1'b1;
        host_word(1, 1);
        host_word(1, 0);
        host_word(1, 0);
        check("restart_rd_count", 32'(rd_cnt[1] - rd_base[1]), 32'd8);
        check("restart_done", 32'(done[1]), 32'd1);
`ifdef ROM_SAVER_CHECKSUM_EN
        check("checksum", 32'(csum[1]), 32'h0024);
`endif

        for (int r = 0; r < 6; r++) begin
            restart(r % 2, int'($urandom_range(0, 30)), 1'b0);
            session(r % 2);
        end

        check("scoreboard_empty0", 32'(q0.size()), 32'd0);
        check("scoreboard_empty1", 32'(q1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_saver.md
ROM_SAVER -- requirements
Module: rom_saver

Interface
- REQ-001 Parameter: RD_LATENCY, default 1, clock cycles from an ioctl_rd pulse to valid ioctl_din (legal range 1..3).
- REQ-002 clk  input  1  single clock; all logic on its rising edge.
- REQ-003 reset_n  input  1  reset, synchronous and active-low.
- REQ-004 host_savedata_upload  input  1  level; high while a host upload session is active.
- REQ-005 host_savedata_req  input  1  level; host requests the next 32-bit word.
- REQ-006 host_savedata_ack  output  1  word valid on host_savedata.
- REQ-007 host_savedata  output  32  packed word; the first byte read sits in [31:24].
- REQ-008 host_savedata_size  input  16  number of bytes to upload.
- REQ-009 host_file_type  input  3  file type: 111 rom, 010 .o, 001 .p.
- REQ-010 ioctl_upload  output  1  equals host_savedata_upload.
- REQ-011 ioctl_index  output  16  file type 111 gives 0x0000, 010 gives 0x001F, any other value gives 0x005F.
- REQ-012 ioctl_rd  output  1  one-cycle read strobe.
- REQ-013 ioctl_addr  output  27  byte address: bits [26:22] are zero, bits [21:0] hold the counter.
- REQ-014 ioctl_din  input  8  read byte, valid exactly RD_LATENCY cycles after ioctl_rd.
- REQ-015 upload_done  output  1  all host_savedata_size bytes have been read.

Function
- REQ-016 FSM states:
  - IDLE: waits for req.
  - READ: drives ioctl_rd=1 for 1 cycle.
  - WAIT: counts RD_LATENCY-1 cycles.
  - CAPTURE: stores the byte in the next lane and increments the address and byte count.
  - PRESENT: drives ack=1 and waits for req=0.
- REQ-017 In IDLE with req=1 and upload_done=0, the FSM enters READ; with upload_done=1 it goes straight to PRESENT and presents 0x00000000 without issuing a read.
- REQ-018 From CAPTURE:
  - if 4 bytes are packed, or the byte count equals size, go to PRESENT;
  - otherwise go to READ.
- REQ-019 Unread lanes of a final partial word are 0x00; no ioctl_rd is ever issued at an address >= size.
- REQ-020 For a full word, ack rises 4*(RD_LATENCY+1)+1 cycles after the edge that samples req=1 in IDLE (9 cycles for RD_LATENCY=1).
- REQ-021 host_savedata is stable while ack=1.
- REQ-022 ack falls on the edge after req is sampled low; the FSM then returns to IDLE.
- REQ-023 The host shall not re-raise req before ack is low; the block ignores req in every state except IDLE.
- REQ-024 upload_done is set when the byte count equals size (including size=0) and stays set until restart.
- REQ-025 The address counter is 22 bits and increments by 1 per byte; it wraps 0x3FFFFF to 0 (unreachable with a 16-bit size).
- REQ-026 A rising edge of host_savedata_upload restarts the session on the following cycle, even mid-word:
  - address, byte count and lanes are cleared, and ack is forced to 0;
  - upload_done is re-evaluated from size;
  - the FSM goes to IDLE.
- REQ-027 upload low forces the FSM to IDLE and drops ack the next cycle; no ioctl_rd is issued while upload is low; counters hold their values.
- REQ-028 If a restart and req=1 arrive in the same cycle, the restart wins; req is served from IDLE on the next cycle.

Reset
- REQ-029 reset_n=0 at a clock edge forces:
  - the FSM to IDLE;
  - ack=0, ioctl_rd=0, host_savedata=0, address=0, byte count=0;
  - upload_done=1.
- REQ-030 Reset takes priority over the restart edge and applies mid-word; a partially packed word is discarded.

Configuration
- REQ-031 Macro ROM_SAVER_CHECKSUM_EN defined:
  - adds output checksum (16 bits), the modulo-2^16 sum of all bytes captured since the last restart;
  - checksum is cleared by reset and by restart;
  - checksum is stable when upload_done=1.
- REQ-032 Macro undefined: the checksum port and its logic are absent; all other behaviour is identical.

Structure
- REQ-033 Package rom_saver_pkg holds:
  - the FSM state enum;
  - the file-type constants (3'b111, 3'b010, 3'b001);
  - the ioctl_index constants (0x0000, 0x001F, 0x005F).
- REQ-034 A single sub-module, word_packer, holds the 4 byte lanes: lane select, zero padding, and clear.

Verification
- REQ-035 Full-word timing: RD_LATENCY=1, size=8, memory bytes 0x01..0x08, two req/ack cycles:
  - words 0x01020304 and 0x05060708;
  - addresses 0..7, exactly 8 ioctl_rd pulses;
  - ack 9 cycles after each sampled req.
- REQ-036 Partial word: size=5 -> second word 0x05000000; 5 ioctl_rd pulses total; upload_done=1 afterwards; a third req returns 0x00000000 with no read.
- REQ-037 Empty file: size=0 -> upload_done=1 one cycle after the restart; req returns 0x00000000; zero ioctl_rd pulses.
- REQ-038 Reset mid-word: reset_n=0 after the 2nd byte of a word -> next cycle ack=0, ioctl_rd=0, ioctl_addr=0; after a new restart the first word again reads addresses 0..3.
- REQ-039 File-type decode: host_file_type 111/010/001/000 -> ioctl_index 0x0000/0x001F/0x005F/0x005F.
- REQ-040 Restart and checksum:
  - restart mid-word with RD_LATENCY=3 -> the next word begins at address 0;
  - with ROM_SAVER_CHECKSUM_EN and bytes 0x01..0x08 -> checksum=0x0024.
